// File: rtl/conv1x1_pkg.sv
// Shared constants and types for the conv1x1 result path.
package conv1x1_pkg;

    // Default conv operand width and FIFO depth.
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    // Conv result width (full-precision product plus bias).
    localparam int RES_W = 2 * DEF_WIDTH;

    typedef logic [RES_W-1:0] res_t;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/conv1x1_result_fifo.sv
// Result FIFO: storage, wrap-around pointers, occupancy and full/empty.
// The head is presented combinationally from storage; a write is never
// bypassed to the output, so a result appears one cycle after capture.
module conv1x1_result_fifo
    import conv1x1_pkg::*;
#(
    parameter  int DW    = RES_W,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          drop
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          pop;
    logic          wr_en;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = !empty && rd_ready;
    // A full FIFO still takes a result when the head leaves in the same cycle.
    assign wr_en    = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rd_valid = !empty;
    assign rdata    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care until a pointer reaches them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count never exceeds DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv1x1_result_sink.sv
// Receiving end of the conv1x1 datapath: buffers every result, re-presents it
// on a valid/ready stream and hands out credit so no result is ever dropped.
// Protocol violations (over-issue, spurious result, overflow) raise a sticky err.
module conv1x1_result_sink
    import conv1x1_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue,
    output logic               credit_ok,
    input  logic               valid_out,
    input  logic [2*WIDTH-1:0] y,
    output logic               m_valid,
    output logic [2*WIDTH-1:0] m_data,
    input  logic               m_ready,
    output logic [CW-1:0]      count,
    output logic               err
);

    logic [CW-1:0] infl;
    logic          infl_zero;
    logic          infl_full;
    logic [CW:0]   committed;
    logic          fifo_full;
    logic          fifo_drop;
    logic          err_set;

    conv1x1_result_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (valid_out),
        .wdata    (y),
        .rd_ready (m_ready),
        .rd_valid (m_valid),
        .rdata    (m_data),
        .count    (count),
        .full     (fifo_full),
        .drop     (fifo_drop)
    );

    assign infl_zero = (infl == '0);
    assign infl_full = (infl == CW'(DEPTH));

    // Credit covers both stored results and results still inside the conv
    // pipe; it depends on registers only so issue never loops back into it.
    assign committed = {1'b0, count} + {1'b0, infl};
    assign credit_ok = (committed < (CW+1)'(DEPTH));

    assign err_set = (issue && !credit_ok) || (valid_out && infl_zero) || fifo_drop;

    // In-flight tracking: issue adds, a returning result retires; both cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl <= '0;
        end else if (issue && !valid_out && !infl_full) begin
            infl <= infl + CW'(1);
        end else if (!issue && valid_out && !infl_zero) begin
            infl <= infl - CW'(1);
        end
    end

    // Sticky violation flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    // Unused-bit guard for the full flag: occupancy is exported via count.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_conv1x1_result_sink.sv
module tb_conv1x1_result_sink;
    import conv1x1_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue = 1'b0;
    logic             inject = 1'b0;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] w = '0;
    logic             credit_ok;
    logic             m_valid;
    logic             err;
    res_t             m_data;
    logic [CW-1:0]    count;
    logic             valid_out;
    res_t             y;

    int total = 0;
    int bad   = 0;

    conv1x1_result_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .credit_ok (credit_ok),
        .valid_out (valid_out),
        .y         (y),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Conv model: 1-cycle latency, y = x*w + 5; inject forces a result with no issue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            y         <= '0;
        end else begin
            valid_out <= issue | inject;
            y         <= RES_W'(x) * RES_W'(w) + RES_W'(5);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        issue = 1'b0; inject = 1'b0; m_ready = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        step(); step();
        rst_n = 1'b1;
        step();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%0b exp=0", m_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (credit_ok !== 1'b1) begin bad++; $display("FAIL rst_credit got=%0b exp=1", credit_ok); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err); end
        total++; if (m_data !== 32'd0) begin bad++; $display("FAIL rst_m_data got=%0d exp=0", m_data); end
    endtask

    task automatic test_single();
        issue = 1'b1; x = 16'd3; w = 16'd4;
        step();
        issue = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", m_valid); end
        step();
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", m_valid); end
        total++; if (m_data !== 32'd17) begin bad++; $display("FAIL single_data got=%0d exp=17", m_data); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", count); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%0b exp=0", m_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%0b exp=0", err); end
    endtask

    task automatic test_back_to_back();
        issue = 1'b1; x = 16'd2; w = 16'd7;
        step();
        x = 16'd1; w = 16'd9;
        step();
        issue = 1'b0;
        total++; if (m_data !== 32'd19) begin bad++; $display("FAIL b2b_first got=%0d exp=19", m_data); end
        step();
        total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
        step();
        total++; if (m_data !== 32'd19) begin bad++; $display("FAIL b2b_stall got=%0d exp=19", m_data); end
        m_ready = 1'b1;
        step();
        total++; if (m_data !== 32'd14) begin bad++; $display("FAIL b2b_second got=%0d exp=14", m_data); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count1 got=%0d exp=1", count); end
        step();
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b exp=0", m_valid); end
        total++; if (m_data !== 32'd0) begin bad++; $display("FAIL b2b_empty_data got=%0d exp=0", m_data); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%0b exp=0", err); end
    endtask

    task automatic test_credit();
        issue = 1'b1; w = 16'd1;
        for (int i = 0; i < 4; i++) begin
            x = 16'(i + 1);
            if (i == 3) begin
                total++; if (credit_ok !== 1'b1) begin bad++; $display("FAIL credit_before4 got=%0b exp=1", credit_ok); end
            end
            step();
        end
        x = 16'd5;
        total++; if (credit_ok !== 1'b0) begin bad++; $display("FAIL credit_after4 got=%0b exp=0", credit_ok); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL credit_err_pre got=%0b exp=0", err); end
        step();
        issue = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL credit_err_set got=%0b exp=1", err); end
        step(); step(); step();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL credit_err_sticky got=%0b exp=1", err); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL credit_count_sat got=%0d exp=4", count); end
        total++; if (m_data !== 32'd6) begin bad++; $display("FAIL credit_head got=%0d exp=6", m_data); end
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL credit_err_clear got=%0b exp=0", err); end
    endtask

    task automatic test_full_push_pop();
        issue = 1'b1; w = 16'd1;
        for (int i = 0; i < 4; i++) begin
            x = 16'(i + 1);
            step();
        end
        issue = 1'b0;
        step();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err got=%0b exp=0", err); end
        // Reaching a push at full needs one issue beyond credit.
        issue = 1'b1; x = 16'd5;
        step();
        issue = 1'b0; m_ready = 1'b1;
        step();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_pp_count got=%0d exp=4", count); end
        total++; if (m_data !== 32'd7) begin bad++; $display("FAIL full_pp_head got=%0d exp=7", m_data); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (m_data !== 32'(8 + i)) begin bad++; $display("FAIL full_order%0d got=%0d exp=%0d", i, m_data, 8 + i); end
        end
        step();
        m_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", count); end
        do_reset();
    endtask

    task automatic test_spurious_and_mid_reset();
        inject = 1'b1; x = 16'd2; w = 16'd2;
        step();
        inject = 1'b0;
        step();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_err got=%0b exp=1", err); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL spur_count got=%0d exp=1", count); end
        total++; if (m_data !== 32'd9) begin bad++; $display("FAIL spur_data got=%0d exp=9", m_data); end
        issue = 1'b1; x = 16'd1; w = 16'd1;
        step();
        issue = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b exp=0", m_valid); end
        total++; if (credit_ok !== 1'b1) begin bad++; $display("FAIL mid_rst_credit got=%0b exp=1", credit_ok); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%0b exp=0", err); end
        step();
        rst_n = 1'b1;
        step(); step();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL post_rst_count got=%0d exp=0", count); end
        total++; if (credit_ok !== 1'b1) begin bad++; $display("FAIL post_rst_credit got=%0b exp=1", credit_ok); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL post_rst_err got=%0b exp=0", err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_credit();
        test_full_push_pop();
        test_spurious_and_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
